// File: rtl/pipe_reg_skid_if.sv
// Valid/ready stream bundle for pipe_reg_skid.
// The master drives valid/data and the slave drives ready.
interface pipe_reg_skid_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready is registered, so back-pressure never forms a combinational path
// across stages. Adds synchronous flush, occupancy reporting and a saturating
// stall-cycle counter.
module pipe_reg_skid #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              flush,
    pipe_reg_skid_if.slave    in_if,
    pipe_reg_skid_if.master   out_if,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_ready_q;
    logic             in_fire, out_fire;

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = (state != EMPTY);
    assign out_if.data  = main_q;
    assign occupancy    = state;

    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = out_if.valid & out_if.ready;

    // Next-state and datapath selection; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = in_if.data;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_if.data;
                    end else if (in_fire) begin
                        skid_nxt  = in_if.data;
                        state_nxt = TWO;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        main_nxt  = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State, payload registers and the registered in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // Saturating count of cycles where a beat waits on downstream; flush does not clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_if.valid && !out_if.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline-stage register for the core: the successor to the fixed enable/flush stage flops.
- Replaces stall/enable wiring with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never needs a combinational ready path across stages.
- Payload width is a parameter: one instance carries a whole bundled stage (data plus control fields).
- Adds synchronous flush, occupancy reporting and a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 16: payload bits per beat.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held beats; active-high.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; registered output.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  downstream payload.
- occupancy  out  2  beats held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- States and outputs:
  - EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - out_valid = (state != EMPTY).
  - in_ready is a flop, next value = (next_state != TWO).
- Reset (reset=0, asynchronous), applied immediately:
  - state = EMPTY; main = 0; skid = 0.
  - in_ready = 1; out_valid = 0; occupancy = 0; stall_cnt = 0.
  - Reset asserted mid-transfer discards all held beats; no partial state survives.
- Transitions, evaluated on the clock edge when flush=0:
  - EMPTY, in_fire: main <= in_data -> ONE. Otherwise stay.
  - ONE, in_fire & out_fire: main <= in_data -> ONE (full throughput, 1 beat/cycle).
  - ONE, in_fire & !out_fire: skid <= in_data -> TWO.
  - ONE, !in_fire & out_fire: -> EMPTY.
  - ONE, neither: hold.
  - TWO (in_ready=0, so in_fire is impossible), out_fire: main <= skid -> ONE.
  - TWO, !out_fire: hold.
- Latency: a beat accepted at edge N is on out_data/out_valid after edge N (1 cycle) when the stage is empty or draining.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush/reset.
- Stability: while out_valid=1 and out_ready=0, out_data is held constant (except on flush/reset).
- Flush (flush=1 at an edge) has highest priority:
  - state -> EMPTY; main and skid cleared to 0; in_ready -> 1.
  - Any input beat offered that cycle is discarded, even if in_fire.
  - out_valid/out_data are unchanged during the flush cycle itself. A downstream out_fire in that cycle counts as a completed transfer; flushing the stage's own copy does not retract it.
- Flush while already EMPTY has no effect beyond clearing registers.
- stall_cnt:
  - Increments each edge with out_valid=1 and out_ready=0, including the flush cycle.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset, not by flush.
- Simultaneous in_fire and out_fire in ONE never changes occupancy.
- in_valid while in_ready=0 has no effect; upstream must hold the beat.
- No combinational path from out_ready to in_ready, or from in_valid/in_data to out_*.

Test Plan:
- Reset:
  - Stimulus: drive reset=0 with random inputs.
  - Required: out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, out_data=0 without a clock edge.
  - Stimulus: release reset.
  - Required: still idle.
- Streaming:
  - Stimulus: out_ready=1; in_valid=1 with in_data 0x0001..0x0008 on consecutive cycles.
  - Required: out_data 0x0001..0x0008 one cycle later, 1 beat/cycle; occupancy stays 1; stall_cnt=0.
- Back-pressure:
  - Stimulus: out_ready=0; send 0xAAAA then 0xBBBB.
  - Required: occupancy 2; in_ready=0; 0xCCCC held upstream.
  - Stimulus: raise out_ready.
  - Required: out order 0xAAAA, 0xBBBB, 0xCCCC; in_ready returns 1 the cycle after the first drain; stall_cnt equals the stalled cycles.
- Flush in TWO:
  - Stimulus: stage holds 0x1111/0x2222; flush=1 with in_valid=1, in_data=0x3333, out_ready=0.
  - Required: next cycle occupancy 0, out_valid=0, in_ready=1; 0x3333 never appears; stall_cnt not cleared.
- Saturation:
  - Stimulus: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_cnt reaches 15 and stays 15.
- Async reset mid-op:
  - Stimulus: occupancy 2; pulse reset low between clock edges.
  - Required: outputs go to reset values immediately; after release, beat 0x4444 passes normally with 1-cycle latency.
